// File: rtl/noise_ctrl_pkg.sv
// Shared constants for the noise channel register block: address map, read-back masks and
// the default frame-sequencer divide ratio.
package noise_ctrl_pkg;

    localparam logic [1:0] ADDR_NR41 = 2'd0;
    localparam logic [1:0] ADDR_NR42 = 2'd1;
    localparam logic [1:0] ADDR_NR43 = 2'd2;
    localparam logic [1:0] ADDR_NR44 = 2'd3;

    // Write-only bits read back as 1
    localparam logic [7:0] NR41_RD_MASK = 8'hFF;
    localparam logic [7:0] NR44_RD_MASK = 8'hBF;

    localparam int unsigned FRAME_DIV_DEFAULT = 8192;

endpackage

// File: rtl/noise_ctrl_if.sv
// Register bus for the noise channel: single-cycle write and read strobes with registered
// read data.
interface noise_ctrl_if;

    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/frame_seq.sv
// 512 Hz frame sequencer: a clock divider feeding a 3-bit step counter, producing the
// 256 Hz length strobe and the 64 Hz envelope strobe. Shared by all sound channels.
module frame_seq #(
    parameter int unsigned FRAME_DIV = 8192
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic len_tick,
    output logic env_tick
);

    localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       step_q;
    logic [2:0]       step_next;

    assign step_next = step_q + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            step_q   <= '0;
            len_tick <= 1'b0;
            env_tick <= 1'b0;
        end else if (!en) begin
            cnt_q    <= '0;
            step_q   <= '0;
            len_tick <= 1'b0;
            env_tick <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            step_q   <= step_next;
            len_tick <= ~step_next[0];
            env_tick <= (step_next == 3'd7);
        end else begin
            cnt_q    <= cnt_q + 1'b1;
            len_tick <= 1'b0;
            env_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/noise_ctrl.sv
// Noise channel control block: NR41..NR44 register file, trigger/length-write pulses and
// the frame-sequencer strobes that clock the length counter and envelope.
module noise_ctrl
    import noise_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_DIV = FRAME_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        power_en,
    noise_ctrl_if.slave bus,
    output logic [5:0]  length_load,
    output logic        length_wr,
    output logic [3:0]  env_init_vol,
    output logic        env_dir,
    output logic [2:0]  env_period,
    output logic [3:0]  clock_shift,
    output logic        width_mode,
    output logic [2:0]  divisor,
    output logic        length_en,
    output logic        dac_en,
    output logic        trigger,
    output logic        len_tick,
    output logic        env_tick
);

    logic [5:0] nr41_q;
    logic [7:0] nr42_q;
    logic [7:0] nr43_q;
    logic       len_en_q;
    logic       length_wr_q;
    logic       trigger_q;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;
    logic [7:0] rd_mux;

    logic wr_nr41, wr_nr42, wr_nr43, wr_nr44;

    assign wr_nr41 = bus.wr_en && (bus.wr_addr == ADDR_NR41);
    assign wr_nr42 = bus.wr_en && (bus.wr_addr == ADDR_NR42);
    assign wr_nr43 = bus.wr_en && (bus.wr_addr == ADDR_NR43);
    assign wr_nr44 = bus.wr_en && (bus.wr_addr == ADDR_NR44);

    // NR42 and NR44 can never be written together, so the current DAC state is post-write
    assign dac_en = |nr42_q[7:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nr41_q      <= '0;
            nr42_q      <= '0;
            nr43_q      <= '0;
            len_en_q    <= 1'b0;
            length_wr_q <= 1'b0;
            trigger_q   <= 1'b0;
        end else if (!power_en) begin
            nr41_q      <= '0;
            nr42_q      <= '0;
            nr43_q      <= '0;
            len_en_q    <= 1'b0;
            length_wr_q <= 1'b0;
            trigger_q   <= 1'b0;
        end else begin
            length_wr_q <= wr_nr41;
            trigger_q   <= wr_nr44 && bus.wr_data[7] && dac_en;
            if (wr_nr41) nr41_q   <= bus.wr_data[5:0];
            if (wr_nr42) nr42_q   <= bus.wr_data;
            if (wr_nr43) nr43_q   <= bus.wr_data;
            if (wr_nr44) len_en_q <= bus.wr_data[6];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.rd_addr)
            ADDR_NR41: rd_mux = NR41_RD_MASK;
            ADDR_NR42: rd_mux = nr42_q;
            ADDR_NR43: rd_mux = nr43_q;
            default:   rd_mux = NR44_RD_MASK | {1'b0, len_en_q, 6'b0};
        endcase
    end

    // Reads stay live while powered off; cleared registers give the masked-zero values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_mux;
        end
    end

    frame_seq #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (power_en),
        .len_tick (len_tick),
        .env_tick (env_tick)
    );

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign length_load  = nr41_q;
    assign length_wr    = length_wr_q;
    assign env_init_vol = nr42_q[7:4];
    assign env_dir      = nr42_q[3];
    assign env_period   = nr42_q[2:0];
    assign clock_shift  = nr43_q[7:4];
    assign width_mode   = nr43_q[3];
    assign divisor      = nr43_q[2:0];
    assign length_en    = len_en_q;
    assign trigger      = trigger_q;

endmodule

// File: tb/tb_noise_ctrl.sv
// Directed bench for noise_ctrl: register writes/reads, trigger gating, power-off clearing,
// frame-sequencer strobe timing and asynchronous reset.
module tb_noise_ctrl;

    localparam int unsigned FD = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       power_en;
    logic [5:0] length_load;
    logic       length_wr;
    logic [3:0] env_init_vol;
    logic       env_dir;
    logic [2:0] env_period;
    logic [3:0] clock_shift;
    logic       width_mode;
    logic [2:0] divisor;
    logic       length_en;
    logic       dac_en;
    logic       trigger;
    logic       len_tick;
    logic       env_tick;

    int vectors     = 0;
    int miscompares = 0;

    noise_ctrl_if bus ();

    noise_ctrl #(
        .FRAME_DIV (FD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .power_en     (power_en),
        .bus          (bus),
        .length_load  (length_load),
        .length_wr    (length_wr),
        .env_init_vol (env_init_vol),
        .env_dir      (env_dir),
        .env_period   (env_period),
        .clock_shift  (clock_shift),
        .width_mode   (width_mode),
        .divisor      (divisor),
        .length_en    (length_en),
        .dac_en       (dac_en),
        .trigger      (trigger),
        .len_tick     (len_tick),
        .env_tick     (env_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        @(negedge clk);
        bus.rd_en   = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    int len_cnt, env_cnt, both_cnt, first_len, first_env, last_len, bad_gap;

    initial begin
        reset_n     = 1'b0;
        power_en    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        #3;
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_length_wr", 32'(length_wr), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_dac_en", 32'(dac_en), 32'd0);
        chk("rst_ticks", 32'({len_tick, env_tick}), 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        power_en = 1'b1;
        @(negedge clk);

        // NR42 = F3
        wr(2'd1, 8'hF3);
        chk("nr42_vol", 32'(env_init_vol), 32'hF);
        chk("nr42_dir", 32'(env_dir), 32'd0);
        chk("nr42_period", 32'(env_period), 32'd3);
        chk("nr42_dac", 32'(dac_en), 32'd1);

        // NR41 write pulse
        wr(2'd0, 8'hC5);
        chk("nr41_len_wr", 32'(length_wr), 32'd1);
        chk("nr41_load", 32'(length_load), 32'h05);
        @(negedge clk);
        chk("nr41_len_wr_end", 32'(length_wr), 32'd0);

        // Trigger with DAC on
        wr(2'd1, 8'hF0);
        wr(2'd3, 8'hC0);
        chk("trig_on", 32'(trigger), 32'd1);
        chk("trig_len_en", 32'(length_en), 32'd1);
        @(negedge clk);
        chk("trig_one_cycle", 32'(trigger), 32'd0);
        rd("rd_nr44_le", 2'd3, 8'hFF);
        rd("rd_nr41", 2'd0, 8'hFF);
        rd("rd_nr42", 2'd1, 8'hF0);
        @(negedge clk);
        chk("rd_valid_pulse", 32'(bus.rd_valid), 32'd0);

        // Trigger suppressed with DAC off
        wr(2'd1, 8'h00);
        chk("dac_off", 32'(dac_en), 32'd0);
        wr(2'd3, 8'h80);
        chk("trig_dac_off", 32'(trigger), 32'd0);
        chk("len_en_clr", 32'(length_en), 32'd0);
        rd("rd_nr44", 2'd3, 8'hBF);

        // Read/write collision returns the old value
        wr(2'd2, 8'h5A);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 2'd2;
        wr(2'd2, 8'h33);
        bus.rd_en   = 1'b0;
        chk("rdwr_old", 32'(bus.rd_data), 32'h5A);
        rd("rd_nr43_new", 2'd2, 8'h33);

        wr(2'd2, 8'h5A);
        chk("nr43_div", 32'(divisor), 32'd2);
        chk("nr43_shift", 32'(clock_shift), 32'd5);
        chk("nr43_width", 32'(width_mode), 32'd1);

        // Power off with writes attempted
        power_en = 1'b0;
        wr(2'd2, 8'hFF);
        chk("off_div", 32'(divisor), 32'd0);
        chk("off_shift", 32'(clock_shift), 32'd0);
        chk("off_width", 32'(width_mode), 32'd0);
        wr(2'd0, 8'h3F);
        chk("off_len_wr", 32'(length_wr), 32'd0);
        chk("off_load", 32'(length_load), 32'd0);
        power_en = 1'b1;

        // Frame sequencer from power-on: k counts posedges since power_en rose
        len_cnt = 0; env_cnt = 0; both_cnt = 0; bad_gap = 0;
        first_len = -1; first_env = -1; last_len = -1;
        for (int k = 1; k <= 32 * int'(FD); k++) begin
            @(negedge clk);
            if (len_tick) begin
                len_cnt++;
                if (first_len < 0) first_len = k;
                if (last_len >= 0 && (k - last_len) != 2 * int'(FD)) bad_gap++;
                last_len = k;
            end
            if (env_tick) begin
                env_cnt++;
                if (first_env < 0) first_env = k;
            end
            if (len_tick && env_tick) both_cnt++;
        end
        chk("fs_len_count", 32'(len_cnt), 32'd16);
        chk("fs_env_count", 32'(env_cnt), 32'd4);
        chk("fs_overlap", 32'(both_cnt), 32'd0);
        chk("fs_first_len", 32'(first_len), 32'(2 * FD));
        chk("fs_first_env", 32'(first_env), 32'(7 * FD));
        chk("fs_len_gap", 32'(bad_gap), 32'd0);

        rd("off_rd_nr43", 2'd2, 8'h00);
        rd("off_rd_nr41", 2'd0, 8'hFF);

        // Asynchronous reset mid-trigger
        wr(2'd1, 8'hF0);
        wr(2'd3, 8'h80);
        chk("rst_pre_trig", 32'(trigger), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_trig", 32'(trigger), 32'd0);
        chk("rst_async_dac", 32'(dac_en), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
